// File: rtl/filtro_pkg.sv
// Shared constants for the filter MAC: Q-format widths, saturation bounds and FSM encoding.
package filtro_pkg;

    localparam int unsigned N      = 25;
    localparam int unsigned FRAC   = 15;
    localparam int unsigned ONE    = 32'(1) << FRAC;
    localparam int unsigned PROD_W = 2 * N;
    localparam int unsigned ACC_W  = 2 * N + 2;

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_SHIFT = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_MAC0  = 3'd3;
    localparam state_t S_MAC1  = 3'd4;
    localparam state_t S_MAC2  = 3'd5;
    localparam state_t S_DONE  = 3'd6;

endpackage

// File: rtl/mac_sat_fk.sv
// Shared signed multiplier feeding a wide accumulator, with floor scaling and
// saturation of the accumulated sum back to N bits.
module mac_sat_fk
    import filtro_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic                add,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] sat_y_c,
    output logic                sat_ovf_c
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(SAT_MIN);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;

    assign prod     = PROD_W'(a) * PROD_W'(b);
    assign prod_ext = ACC_W'(prod);

    // Three-term sum fits in ACC_W bits, so the accumulator never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= prod_ext;
        end else if (add) begin
            acc <= acc + prod_ext;
        end
    end

    assign scaled = acc >>> FRAC;

    always_comb begin
        sat_y_c   = scaled[N-1:0];
        sat_ovf_c = 1'b0;
        if (scaled > MAX_EXT) begin
            sat_y_c   = SAT_MAX;
            sat_ovf_c = 1'b1;
        end else if (scaled < MIN_EXT) begin
            sat_y_c   = SAT_MIN;
            sat_ovf_c = 1'b1;
        end
    end

endmodule

// File: rtl/filtro_mac_fk.sv
// Filter-sample consumer: strobes the delay line, then computes
// a0*fk + a1*fk_1 + a2*fk_2 over three cycles on one multiplier.
module filtro_mac_fk
    import filtro_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] fk,
    input  logic signed [N-1:0] fk_1,
    input  logic signed [N-1:0] fk_2,
    input  logic signed [N-1:0] a0,
    input  logic signed [N-1:0] a1,
    input  logic signed [N-1:0] a2,
    output logic                shift,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] y,
    output logic                ovf
);

    state_t state;
    state_t next_state;

    logic                shift_d;
    logic                busy_d;
    logic                done_d;
    logic                acc_clear;
    logic                acc_load;
    logic                acc_add;
    logic signed [N-1:0] coef;
    logic signed [N-1:0] tap;
    logic signed [N-1:0] sat_y_c;
    logic                sat_ovf_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: next_state = S_WAIT;
            S_WAIT:  next_state = S_MAC0;
            S_MAC0:  next_state = S_MAC1;
            S_MAC1:  next_state = S_MAC2;
            S_MAC2:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from next_state so the registered outputs line up with the state.
    always_comb begin
        shift_d   = (next_state == S_SHIFT);
        busy_d    = (next_state == S_SHIFT) || (next_state == S_WAIT) ||
                    (next_state == S_MAC0)  || (next_state == S_MAC1) ||
                    (next_state == S_MAC2);
        done_d    = (state == S_DONE);
        acc_clear = (state == S_SHIFT);
        acc_load  = (state == S_MAC0);
        acc_add   = (state == S_MAC1) || (state == S_MAC2);
        coef      = a0;
        tap       = fk;
        case (state)
            S_MAC1: begin
                coef = a1;
                tap  = fk_1;
            end
            S_MAC2: begin
                coef = a2;
                tap  = fk_2;
            end
            default: begin
                coef = a0;
                tap  = fk;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            ovf   <= 1'b0;
        end else begin
            shift <= shift_d;
            busy  <= busy_d;
            done  <= done_d;
            if (done_d) begin
                y   <= sat_y_c;
                ovf <= sat_ovf_c;
            end
        end
    end

    mac_sat_fk u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear),
        .load      (acc_load),
        .add       (acc_add),
        .a         (coef),
        .b         (tap),
        .sat_y_c   (sat_y_c),
        .sat_ovf_c (sat_ovf_c)
    );

endmodule

// File: tb/tb_filtro_mac_fk.sv
// Bench for filtro_mac_fk: a delay line driven by shift, a directed vector table,
// hand sequences for start/reset corner cases, and random runs against a sum-of-products model.
module tb_filtro_mac_fk;
    import filtro_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic signed [N-1:0] din = '0;
    logic signed [N-1:0] tap0 = '0;
    logic signed [N-1:0] tap1 = '0;
    logic signed [N-1:0] tap2 = '0;
    logic signed [N-1:0] a0 = '0;
    logic signed [N-1:0] a1 = '0;
    logic signed [N-1:0] a2 = '0;
    logic                shift;
    logic                busy;
    logic                done;
    logic signed [N-1:0] y;
    logic                ovf;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_done_cyc = 0;
    longint hist[$];

    typedef struct {
        int din;
        int c0;
        int c1;
        int c2;
        int y;
        bit ovf;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The delay line the block drives: taps age on each shift strobe.
    always @(posedge clk) begin
        if (shift) begin
            tap2 <= tap1;
            tap1 <= tap0;
            tap0 <= din;
        end
    end

    filtro_mac_fk dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .fk    (tap0),
        .fk_1  (tap1),
        .fk_2  (tap2),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .shift (shift),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .ovf   (ovf)
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Plain arithmetic reference: exact sum, floor divide by 2**FRAC, clamp.
    function automatic void model(input longint c0, input longint c1, input longint c2,
                                  output longint ye, output bit oe);
        longint s;
        longint r;
        s  = c0 * hist[0] + c1 * hist[1] + c2 * hist[2];
        r  = s >>> FRAC;
        oe = 1'b0;
        ye = r;
        if (r > 64'sd16777215) begin
            ye = 64'sd16777215;
            oe = 1'b1;
        end else if (r < -64'sd16777216) begin
            ye = -64'sd16777216;
            oe = 1'b1;
        end
    endfunction

    // One operation from an IDLE negedge; poke_k raises start again at that observed cycle.
    task automatic run_op(input int din_v, input int c0, input int c1, input int c2,
                          input int poke_k, output longint y_got, output bit ovf_got);
        int k;
        int shifts;
        int busys;
        bit seen;
        din    = N'(din_v);
        a0     = N'(c0);
        a1     = N'(c1);
        a2     = N'(c2);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        k      = 0;
        shifts = 0;
        busys  = 0;
        seen   = 1'b0;
        while (!seen && k < 20) begin
            if (shift) shifts++;
            if (busy)  busys++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
                start = (k == poke_k);
            end
        end
        start = 1'b0;
        last_done_cyc = cyc;
        hist.push_front(longint'(N'(din_v)) <<< (64 - N) >>> (64 - N));
        check("latency", seen ? k : -1, 6);
        check("shift_count", shifts, 1);
        check("busy_cycles", busys, 5);
        y_got   = longint'(y);
        ovf_got = ovf;
    endtask

    initial begin
        longint yg;
        bit     og;
        longint ye;
        bit     oe;
        int     t_done;
        int     cnt;

        hist = '{0, 0, 0};

        vecs[0]  = '{1000,      int'(ONE), 0, 0, 1000, 1'b0};
        vecs[1]  = '{300,       10923, 10923, 10923, 433, 1'b0};
        vecs[2]  = '{600,       10923, 10923, 10923, 633, 1'b0};
        vecs[3]  = '{900,       10923, 10923, 10923, 600, 1'b0};
        vecs[4]  = '{-3,        16384, 0, 0, -2, 1'b0};
        vecs[5]  = '{3,         16384, 0, 0, 1, 1'b0};
        vecs[6]  = '{16777215,  16777215, 16777215, 16777215, 16777215, 1'b1};
        vecs[7]  = '{16777215,  16777215, 16777215, 16777215, 16777215, 1'b1};
        vecs[8]  = '{16777215,  16777215, 16777215, 16777215, 16777215, 1'b1};
        vecs[9]  = '{-16777216, 16777215, 16777215, 16777215, 16777215, 1'b1};
        vecs[10] = '{-16777216, 16777215, 16777215, 16777215, -16777216, 1'b1};
        vecs[11] = '{-16777216, 16777215, 16777215, 16777215, -16777216, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_shift", shift, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_y", y, 0);
        check("reset_ovf", ovf, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].din, vecs[i].c0, vecs[i].c1, vecs[i].c2, -1, yg, og);
            check($sformatf("vec%0d_y", i), yg, vecs[i].y);
            check($sformatf("vec%0d_ovf", i), og, vecs[i].ovf);
        end

        // Reset during MAC1 clears outputs and suppresses done.
        din   = N'(77);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_shift", shift, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_ovf", ovf, 0);
        check("rst_mid_y", y, 0);
        hist.push_front(64'sd77);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || shift) cnt++;
        end
        check("rst_mid_no_done", cnt, 0);
        run_op(-5000, 20000, -12000, 7000, -1, yg, og);
        model(20000, -12000, 7000, ye, oe);
        check("after_rst_y", yg, ye);
        check("after_rst_ovf", og, oe);

        // A second start during MAC1 is ignored.
        run_op(4321, 30000, 5000, -9000, 3, yg, og);
        model(30000, 5000, -9000, ye, oe);
        check("poke_y", yg, ye);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || shift) cnt++;
        end
        check("poke_no_extra", cnt, 0);

        // Start in the done cycle is accepted; next done seven cycles on.
        run_op(1111, 8000, 8000, 8000, -1, yg, og);
        t_done = last_done_cyc;
        run_op(-2222, 9000, -3000, 1000, -1, yg, og);
        check("b2b_spacing", last_done_cyc - t_done, 7);
        model(9000, -3000, 1000, ye, oe);
        check("b2b_y", yg, ye);
        check("b2b_ovf", og, oe);

        for (int i = 0; i < 30; i++) begin
            int dv;
            int c0;
            int c1;
            int c2;
            dv = (i % 3 == 0) ? int'($urandom_range(0, 4000)) - 2000
                              : int'(N'($urandom)) <<< 7 >>> 7;
            if (i % 4 == 3) begin
                c0 = int'(N'($urandom)) <<< 7 >>> 7;
                c1 = int'(N'($urandom)) <<< 7 >>> 7;
                c2 = int'(N'($urandom)) <<< 7 >>> 7;
            end else begin
                c0 = int'($urandom_range(0, 65535)) - 32768;
                c1 = int'($urandom_range(0, 65535)) - 32768;
                c2 = int'($urandom_range(0, 65535)) - 32768;
            end
            if (i % 5 == 0) repeat (2) @(negedge clk);
            run_op(dv, c0, c1, c2, -1, yg, og);
            model(c0, c1, c2, ye, oe);
            check($sformatf("rand%0d_y", i), yg, ye);
            check($sformatf("rand%0d_ovf", i), og, oe);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
